// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: A - B - borrow_in, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_borrow_in,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_diff,
  output logic         o_borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic         o_overflow
`endif
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic           bin_q, bin_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           d_bit, bout, last;

  assign d_bit = a_q[0] ^ b_q[0] ^ bin_q;
  assign bout  = (~a_q[0] & b_q[0]) | (~a_q[0] & bin_q) | (b_q[0] & bin_q);
  assign last  = (cnt_q == CW'(N - 1));

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic ovf_q, ovf_d;
  // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last) ovf_d = bin_q ^ bout;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end
  assign o_overflow = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          a_d     = i_a;
          b_d     = i_b;
          bin_d   = i_borrow_in;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = {d_bit, diff_q[N-1:1]};
        bin_d  = bout;
        cnt_d  = cnt_q + CW'(1);
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bin_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_busy       = (state_q == RUN);
  assign o_done       = (state_q == DONE);
  assign o_diff       = diff_q;
  assign o_borrow_out = bin_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks on an 8-bit instance plus a model-checked sweep at N = 2, 8, 16.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic       d_start, d_bin, d_busy, d_done, d_bout;
  logic [7:0] d_a, d_b, d_diff;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic       d_ovf;
`endif

  serial_subtractor #(.N(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(d_start), .i_a(d_a), .i_b(d_b),
    .i_borrow_in(d_bin), .o_busy(d_busy), .o_done(d_done), .o_diff(d_diff),
    .o_borrow_out(d_bout)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    , .o_overflow(d_ovf)
`endif
  );

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb, input logic eo);
    int nb, cyc, both;
    nb = 0; cyc = 0; both = 0;
    @(negedge clk); d_a = a; d_b = b; d_bin = bin; d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    while (!d_done && cyc < 20) begin
      if (d_busy) nb++;
      @(negedge clk); cyc++;
    end
    if (d_busy && d_done) both++;
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_done"}, {31'd0, d_done}, 1);
    chk({tag, "_excl"}, both, 0);
    chk({tag, "_diff"}, {24'd0, d_diff}, {24'd0, ed});
    chk({tag, "_bout"}, {31'd0, d_bout}, {31'd0, eb});
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk({tag, "_ovf"}, {31'd0, d_ovf}, {31'd0, eo});
`else
    if (eo) nb = 0;
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, d_done}, 0);
    chk({tag, "_diff_hold"}, {24'd0, d_diff}, {24'd0, ed});
  endtask

  logic sweep_go = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int NW = (g == 0) ? 2 : (g == 1) ? 8 : 16;
    logic          start, bin, busy, done, bout;
    logic [NW-1:0] a, b, diff;
    logic          fin = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic          ovf;
`endif
    serial_subtractor #(.N(NW)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
      .i_borrow_in(bin), .o_busy(busy), .o_done(done), .o_diff(diff),
      .o_borrow_out(bout)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      , .o_overflow(ovf)
`endif
    );

    initial begin
      logic [NW:0] exp_u, exp_s;
      int n;
      start = 1'b0; a = '0; b = '0; bin = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        a = NW'($urandom); b = NW'($urandom); bin = 1'($urandom_range(0, 1)); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < NW + 4) begin
          @(negedge clk); n++;
        end
        exp_u = {1'b0, a} - {1'b0, b} - (NW+1)'(bin);
        exp_s = {a[NW-1], a} - {b[NW-1], b} - (NW+1)'(bin);
        chk($sformatf("sw%0d_lat", NW), n, NW);
        chk($sformatf("sw%0d_diff", NW), 32'(diff), 32'(exp_u[NW-1:0]));
        chk($sformatf("sw%0d_bout", NW), {31'd0, bout}, {31'd0, exp_u[NW]});
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk($sformatf("sw%0d_ovf", NW), {31'd0, ovf}, {31'd0, exp_s[NW] ^ exp_s[NW-1]});
`else
        if (exp_s[0]) n = 0;
`endif
      end
      fin = 1'b1;
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0; d_start = 1'b0; d_a = '0; d_b = '0; d_bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, d_busy}, 0);
    chk("rst_done", {31'd0, d_done}, 0);
    chk("rst_diff", {24'd0, d_diff}, 0);
    chk("rst_bout", {31'd0, d_bout}, 0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk("rst_ovf", {31'd0, d_ovf}, 0);
`endif
    rst_n = 1'b1;

    run_op("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("t0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("t100f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);

    // start held high, operands scrambled while running
    @(negedge clk); d_a = 8'h33; d_b = 8'h11; d_bin = 1'b0; d_start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!d_done && cyc < 20) begin
      d_a = 8'($urandom); d_b = 8'($urandom); d_bin = 1'($urandom_range(0, 1));
      @(negedge clk); cyc++;
    end
    chk("hold_lat", cyc, 8);
    chk("hold_diff", {24'd0, d_diff}, 32'h22);
    chk("hold_bout", {31'd0, d_bout}, 0);
    d_a = 8'h44; d_b = 8'h04; d_bin = 1'b0;
    @(negedge clk);
    chk("hold_idle_busy", {31'd0, d_busy}, 0);
    chk("hold_idle_done", {31'd0, d_done}, 0);
    @(negedge clk);
    chk("hold_restart", {31'd0, d_busy}, 1);
    d_start = 1'b0;
    cyc = 0;
    while (!d_done && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    chk("hold2_diff", {24'd0, d_diff}, 32'h40);
    chk("hold2_bout", {31'd0, d_bout}, 0);

    // reset during RUN after three bits processed
    @(negedge clk); d_a = 8'h5A; d_b = 8'h3C; d_bin = 1'b0; d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", {31'd0, d_busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, d_busy}, 0);
    chk("mid_done", {31'd0, d_done}, 0);
    chk("mid_diff", {24'd0, d_diff}, 0);
    chk("mid_bout", {31'd0, d_bout}, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("tff00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);

    run_op("t8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("t0503", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    sweep_go = 1'b1;
    cyc = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && cyc < 60000) begin
      @(posedge clk); cyc++;
    end
    chk("sweep_finish", {31'd0, g_sw[0].fin && g_sw[1].fin && g_sw[2].fin}, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
